// File: rtl/scoreboard_prf.sv
// scoreboard_prf: per-register busy tracking for the backend issue queues,
//   with timed wakeups and branch checkpoints.
// Latency: a set is visible to queries one cycle later; clears, latency-0
//   schedules and expiring counters bypass into the same-cycle query result.
// Backpressure: none; every request is accepted in the cycle it is presented.
// Ports:
//   clock, reset (sync, active-low), flush      : clock / state clear
//   set_valid/set_index                         : dispatch, mark busy
//   clr_valid/clr_index                         : writeback, mark ready
//   sch_valid/sch_index/sch_lat                 : ready after sch_lat cycles
//   ckpt_take/_id, ckpt_restore/_id             : snapshot / mispredict restore
//   qry_index -> qry_busy                       : combinational busy lookup
//   sch_pending                                 : some wakeup counter running
module scoreboard_prf #(
  parameter int PRF_SIZE  = 64,
  parameter int SET_PORTS = 4,
  parameter int CLR_PORTS = 4,
  parameter int SCH_PORTS = 2,
  parameter int LAT_W     = 3,
  parameter int QRY_PORTS = 24,
  parameter int CKPT_NUM  = 4,
  localparam int IDX_W    = $clog2(PRF_SIZE),
  localparam int CK_W     = $clog2(CKPT_NUM)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [SET_PORTS-1:0]                set_valid,
  input  logic [SET_PORTS-1:0][IDX_W-1:0]     set_index,
  input  logic [CLR_PORTS-1:0]                clr_valid,
  input  logic [CLR_PORTS-1:0][IDX_W-1:0]     clr_index,
  input  logic [SCH_PORTS-1:0]                sch_valid,
  input  logic [SCH_PORTS-1:0][IDX_W-1:0]     sch_index,
  input  logic [SCH_PORTS-1:0][LAT_W-1:0]     sch_lat,
  input  logic                                ckpt_take,
  input  logic [CK_W-1:0]                     ckpt_take_id,
  input  logic                                ckpt_restore,
  input  logic [CK_W-1:0]                     ckpt_restore_id,
  input  logic [QRY_PORTS-1:0][IDX_W-1:0]     qry_index,
  output logic [QRY_PORTS-1:0]                qry_busy,
  output logic                                sch_pending
);

  logic [PRF_SIZE-1:0] sb_q, sb_d;
  logic [PRF_SIZE-1:0] set_req, clr_now, sb_upd;
  logic [LAT_W-1:0]    cnt_q  [PRF_SIZE];
  logic [LAT_W-1:0]    cnt_d  [PRF_SIZE];
  logic [PRF_SIZE-1:0] snap_q [CKPT_NUM];
  logic [PRF_SIZE-1:0] snap_d [CKPT_NUM];

  // Per-entry set and clear requests for this cycle. Entry 0 is the
  // hard-wired zero register and never takes part.
  always_comb begin
    set_req = '0;
    clr_now = '0;
    for (int s = 0; s < SET_PORTS; s++) begin
      if (set_valid[s]) set_req[set_index[s]] = 1'b1;
    end
    for (int c = 0; c < CLR_PORTS; c++) begin
      if (clr_valid[c]) clr_now[clr_index[c]] = 1'b1;
    end
    // A zero-latency schedule is just another writeback port.
    for (int w = 0; w < SCH_PORTS; w++) begin
      if (sch_valid[w] && (sch_lat[w] == '0)) clr_now[sch_index[w]] = 1'b1;
    end
    // Counter at 1 means the wakeup lands this cycle.
    for (int e = 0; e < PRF_SIZE; e++) begin
      if (cnt_q[e] == LAT_W'(1)) clr_now[e] = 1'b1;
    end
    set_req[0] = 1'b0;
    clr_now[0] = 1'b0;
  end

  always_comb begin
    // Clear wins over set on the same entry.
    sb_upd = (sb_q | set_req) & ~clr_now;
    sb_d   = sb_upd;

    for (int e = 0; e < PRF_SIZE; e++) begin
      cnt_d[e] = (cnt_q[e] != '0) ? cnt_q[e] - LAT_W'(1) : '0;
    end
    // Later schedules overwrite a running counter; higher port wins a tie.
    for (int w = 0; w < SCH_PORTS; w++) begin
      if (sch_valid[w] && (sch_lat[w] != '0) && (sch_index[w] != '0)) begin
        cnt_d[sch_index[w]] = sch_lat[w];
      end
    end

    // Writebacks after a checkpoint must also be reflected in it, otherwise
    // a restore would resurrect registers that are already written.
    for (int k = 0; k < CKPT_NUM; k++) begin
      snap_d[k] = snap_q[k] & ~clr_now;
    end

    if (flush) begin
      sb_d = '0;
      for (int e = 0; e < PRF_SIZE; e++) cnt_d[e] = '0;
      for (int k = 0; k < CKPT_NUM; k++) snap_d[k] = '0;
    end else if (ckpt_restore) begin
      // Wrong-path sets and any same-cycle take are dropped; wakeups for
      // entries that come back ready are cancelled.
      sb_d = snap_q[ckpt_restore_id] & ~clr_now;
      for (int e = 0; e < PRF_SIZE; e++) begin
        if (!sb_d[e]) cnt_d[e] = '0;
      end
    end else if (ckpt_take) begin
      snap_d[ckpt_take_id] = sb_upd;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sb_q <= '0;
      for (int e = 0; e < PRF_SIZE; e++) cnt_q[e] <= '0;
      for (int k = 0; k < CKPT_NUM; k++) snap_q[k] <= '0;
    end else begin
      sb_q <= sb_d;
      for (int e = 0; e < PRF_SIZE; e++) cnt_q[e] <= cnt_d[e];
      for (int k = 0; k < CKPT_NUM; k++) snap_q[k] <= snap_d[k];
    end
  end

  // Queries see registered state minus this cycle's clears (bypass).
  always_comb begin
    qry_busy = '0;
    for (int i = 0; i < QRY_PORTS; i++) begin
      qry_busy[i] = (qry_index[i] != '0) & sb_q[qry_index[i]] & ~clr_now[qry_index[i]];
    end
  end

  always_comb begin
    sch_pending = 1'b0;
    for (int e = 0; e < PRF_SIZE; e++) begin
      if (cnt_q[e] != '0) sch_pending = 1'b1;
    end
  end

endmodule

// File: tb/tb_scoreboard_prf.sv
module tb_scoreboard_prf;

  localparam int IDX_W = 6;
  localparam int LAT_W = 3;
  localparam int CK_W  = 2;
  localparam int NQ    = 24;

  logic clock = 1'b0;
  logic reset, flush;
  logic [3:0]             set_valid;
  logic [3:0][IDX_W-1:0]  set_index;
  logic [3:0]             clr_valid;
  logic [3:0][IDX_W-1:0]  clr_index;
  logic [1:0]             sch_valid;
  logic [1:0][IDX_W-1:0]  sch_index;
  logic [1:0][LAT_W-1:0]  sch_lat;
  logic                   ckpt_take, ckpt_restore;
  logic [CK_W-1:0]        ckpt_take_id, ckpt_restore_id;
  logic [NQ-1:0][IDX_W-1:0] qry_index;
  logic [NQ-1:0]          qry_busy;
  logic                   sch_pending;

  always #5 clock = ~clock;

  scoreboard_prf dut (
    .clock(clock), .reset(reset), .flush(flush),
    .set_valid(set_valid), .set_index(set_index),
    .clr_valid(clr_valid), .clr_index(clr_index),
    .sch_valid(sch_valid), .sch_index(sch_index), .sch_lat(sch_lat),
    .ckpt_take(ckpt_take), .ckpt_take_id(ckpt_take_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .qry_index(qry_index), .qry_busy(qry_busy), .sch_pending(sch_pending)
  );

  // kind 0: one query port, kind 1: sch_pending, kind 2: whole qry_busy vector
  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [23:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic exp_q(input int port, input logic v, input string nm);
    sbq.push_back('{cyc, 0, port, {23'b0, v}, nm});
  endtask
  task automatic exp_p(input logic v, input string nm);
    sbq.push_back('{cyc, 1, 0, {23'b0, v}, nm});
  endtask
  task automatic exp_v(input logic [23:0] v, input string nm);
    sbq.push_back('{cyc, 2, 0, v, nm});
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  exp_t        e;
  logic [23:0] act;
  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      case (e.kind)
        0:       act = {23'b0, qry_busy[e.port]};
        1:       act = {23'b0, sch_pending};
        default: act = qry_busy;
      endcase
      checks++;
      if (act !== e.val || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clock);
    #1;
    cyc++;
    flush        = 1'b0;
    set_valid    = '0;
    clr_valid    = '0;
    sch_valid    = '0;
    ckpt_take    = 1'b0;
    ckpt_restore = 1'b0;
  endtask

  task automatic sset(input int p, input int idx);
    set_valid[p] = 1'b1; set_index[p] = IDX_W'(idx);
  endtask
  task automatic sclr(input int p, input int idx);
    clr_valid[p] = 1'b1; clr_index[p] = IDX_W'(idx);
  endtask
  task automatic ssch(input int p, input int idx, input int lat);
    sch_valid[p] = 1'b1; sch_index[p] = IDX_W'(idx); sch_lat[p] = LAT_W'(lat);
  endtask
  task automatic q(input int p, input int idx);
    qry_index[p] = IDX_W'(idx);
  endtask
  task automatic take(input int id);
    ckpt_take = 1'b1; ckpt_take_id = CK_W'(id);
  endtask
  task automatic restore(input int id);
    ckpt_restore = 1'b1; ckpt_restore_id = CK_W'(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0;
    set_valid = '0; set_index = '0; clr_valid = '0; clr_index = '0;
    sch_valid = '0; sch_index = '0; sch_lat = '0;
    ckpt_take = 1'b0; ckpt_take_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
    qry_index = '0;

    // Reset state
    next_cyc(); q(0, 5); exp_v(24'h0, "rst_qry"); exp_p(1'b0, "rst_pend");
    next_cyc(); reset = 1'b1;

    // Set 5, 9 (and ignored 0): visible the following cycle
    next_cyc(); sset(0, 5); sset(1, 9); sset(2, 0); q(0, 5); q(1, 9); q(2, 0);
    exp_q(0, 1'b0, "set5_same_cyc"); exp_q(1, 1'b0, "set9_same_cyc");
    next_cyc(); exp_q(0, 1'b1, "set5"); exp_q(1, 1'b1, "set9"); exp_q(2, 1'b0, "idx0");

    // Writeback clear bypass
    next_cyc(); sset(0, 12); q(3, 12);
    next_cyc(); exp_q(3, 1'b1, "busy12");
    next_cyc(); sclr(0, 12); exp_q(3, 1'b0, "clr12_bypass");
    next_cyc(); exp_q(3, 1'b0, "clr12_held");

    // Latency-0 schedule acts like a clear port
    next_cyc(); sset(0, 25); q(5, 25);
    next_cyc(); exp_q(5, 1'b1, "busy25");
    next_cyc(); ssch(1, 25, 0); exp_q(5, 1'b0, "sch0_bypass");
    next_cyc(); exp_q(5, 1'b0, "sch0_held"); exp_p(1'b0, "sch0_no_pend");

    // Schedule L=3 issued in cycle t: drops in t+3, sb clear by t+4
    next_cyc(); sset(0, 20); q(4, 20);
    next_cyc(); ssch(0, 20, 3); exp_q(4, 1'b1, "sch20_t");
    next_cyc(); exp_q(4, 1'b1, "sch20_t1"); exp_p(1'b1, "pend_t1");
    next_cyc(); exp_q(4, 1'b1, "sch20_t2"); exp_p(1'b1, "pend_t2");
    next_cyc(); exp_q(4, 1'b0, "sch20_t3_drop");
    next_cyc(); exp_q(4, 1'b0, "sch20_t4"); exp_p(1'b0, "pend_done");

    // Checkpoint with same-cycle set, later set and clear, then restore
    next_cyc(); sset(0, 7); q(0, 30); q(1, 7); q(2, 31); q(3, 5);
    next_cyc(); take(1); sset(0, 30); exp_q(1, 1'b1, "busy7");
    next_cyc(); sset(0, 31); exp_q(0, 1'b1, "busy30");
    next_cyc(); sclr(0, 7); exp_q(2, 1'b1, "busy31");
    next_cyc(); restore(1); exp_q(2, 1'b1, "pre_restore31"); exp_q(1, 1'b0, "cleared7");
    next_cyc(); exp_q(0, 1'b1, "rest_30"); exp_q(1, 1'b0, "rest_7");
    exp_q(2, 1'b0, "rest_31"); exp_q(3, 1'b1, "rest_5");

    // Restore cancels a wrong-path wakeup on 40
    next_cyc(); take(2);
    next_cyc(); sset(0, 40); q(4, 40);
    next_cyc(); ssch(0, 40, 5); exp_q(4, 1'b1, "busy40");
    next_cyc(); restore(2); exp_p(1'b1, "pend40"); exp_q(4, 1'b1, "busy40_pre");
    next_cyc(); exp_q(4, 1'b0, "rest_40"); exp_p(1'b0, "rest_cnt_zero"); sset(0, 40);
    next_cyc(); exp_q(4, 1'b1, "reset40_busy");
    next_cyc();
    next_cyc(); exp_q(4, 1'b1, "no_stale_wake");
    next_cyc(); exp_q(4, 1'b1, "40_still_busy"); exp_p(1'b0, "no_pend_40");

    // Same-cycle set and clear on one index
    next_cyc(); sset(0, 3); sclr(0, 3); q(5, 3); exp_q(5, 1'b0, "setclr3_same");
    next_cyc(); exp_q(5, 1'b0, "setclr3");

    // Restore and take on the same never-taken id: restore wins
    next_cyc(); sset(0, 50); q(6, 50); q(7, 51);
    next_cyc(); restore(3); take(3); sset(0, 51); exp_q(6, 1'b1, "busy50");
    next_cyc(); exp_q(6, 1'b0, "rt_50"); exp_q(7, 1'b0, "rt_51");
    exp_q(3, 1'b0, "rt_5"); exp_q(4, 1'b0, "rt_40");
    next_cyc(); restore(3);
    next_cyc(); exp_q(3, 1'b0, "snap3_untouched"); exp_q(0, 1'b0, "snap3_30");

    // Flush with 8 busy entries
    next_cyc();
    for (int i = 0; i < NQ; i++) q(i, 0);
    q(0, 60); q(1, 61); q(2, 62); q(3, 63); q(4, 1); q(5, 2); q(6, 4); q(7, 6);
    sset(0, 60); sset(1, 61); sset(2, 62); sset(3, 63);
    next_cyc(); sset(0, 1); sset(1, 2); sset(2, 4); sset(3, 6);
    next_cyc(); flush = 1'b1; exp_v(24'h0000FF, "pre_flush");
    next_cyc(); exp_v(24'h000000, "post_flush");

    // Reset during a countdown: no wakeup afterwards
    next_cyc(); sset(0, 33); q(0, 33);
    next_cyc(); ssch(0, 33, 4);
    next_cyc(); reset = 1'b0; exp_q(0, 1'b1, "busy33_pre_rst"); exp_p(1'b1, "pend_pre_rst");
    next_cyc(); reset = 1'b1; exp_q(0, 1'b0, "rst33"); exp_p(1'b0, "rst_mid_pend");
    next_cyc(); sset(0, 33);
    next_cyc(); exp_q(0, 1'b1, "33_after_rst");
    next_cyc();
    next_cyc(); exp_q(0, 1'b1, "33_no_wake"); exp_p(1'b0, "pend_after_rst");

    next_cyc();
    next_cyc();
    if (sbq.size() != 0) begin
      $display("FAIL unchecked_expectations left=%0d expected=0", sbq.size());
      errors += sbq.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
